// File: rtl/bcd_counter_display_if.sv
// Bundle of the control inputs and display/count outputs of bcd_counter_display.
// master drives enable/dec/load/values; slave is the counter itself.
interface bcd_counter_display_if #(
  parameter int DIGITS = 4
) ();
  logic                  enable;
  logic                  dec;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   threshold_value;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  threshold;
  logic                  wrap;
  logic [6:0]            sevenSeg;
  logic [7:0]            anodes;

  modport master (
    output enable, dec, load, load_value, threshold_value,
    input  count_bcd, threshold, wrap, sevenSeg, anodes
  );

  modport slave (
    input  enable, dec, load, load_value, threshold_value,
    output count_bcd, threshold, wrap, sevenSeg, anodes
  );
endinterface

// File: rtl/bcd_counter_display.sv
// DIGITS-wide BCD up/down counter with load, threshold match, wrap pulse and a
// multiplexed active-low 7-segment driver. Count and scan ticks come from
// internal prescalers on clk_in.
// Optional: define BCD_LEADING_ZERO_BLANK_EN to blank digits above the most
// significant non-zero digit (digit 0 always shown).
module bcd_counter_display #(
  parameter int CLK_IN_F = 100000000,
  parameter int COUNT_F  = 4,
  parameter int SCAN_F   = 300,
  parameter int DIGITS   = 4
) (
  input  logic clk_in,
  input  logic reset,
  bcd_counter_display_if.slave bus
);
  localparam int P_C = CLK_IN_F / COUNT_F;
  localparam int P_S = CLK_IN_F / SCAN_F;
  localparam int PCW = $clog2(P_C);
  localparam int PSW = $clog2(P_S);
  localparam int W   = 4 * DIGITS;

  logic [PCW-1:0] cnt_pre_q;
  logic [PSW-1:0] scan_pre_q;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   load_sat, count_inc, count_dec;
  logic           all9, all0, carry, borrow;
  logic [3:0]     dig, ldg;
  logic           step, scan_tick;
  logic           threshold_q, wrap_q;
  logic [2:0]     ptr_q, sel_q;
  logic           active_q;
  logic [7:0]     anodes_q;
  logic [6:0]     seg_q;
  logic [3:0]     sel_digit;
  logic           sel_blank;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0000001;
      4'd1:    seg_enc = 7'b1001111;
      4'd2:    seg_enc = 7'b0010010;
      4'd3:    seg_enc = 7'b0000110;
      4'd4:    seg_enc = 7'b1001100;
      4'd5:    seg_enc = 7'b0100100;
      4'd6:    seg_enc = 7'b0100000;
      4'd7:    seg_enc = 7'b0001111;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0000100;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  assign step      = bus.enable && !bus.load && (cnt_pre_q == PCW'(P_C - 1));
  assign scan_tick = (scan_pre_q == PSW'(P_S - 1));

  // Per-digit load saturation and ripple-carry BCD increment/decrement.
  always_comb begin
    load_sat  = '0;
    count_inc = '0;
    count_dec = '0;
    all9      = 1'b1;
    all0      = 1'b1;
    carry     = 1'b1;
    borrow    = 1'b1;
    dig       = '0;
    ldg       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      ldg = bus.load_value[4*i +: 4];
      load_sat[4*i +: 4] = (ldg > 4'd9) ? 4'd9 : ldg;
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (carry) begin
        count_inc[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        carry = (dig == 4'd9);
      end else begin
        count_inc[4*i +: 4] = dig;
      end
      if (borrow) begin
        count_dec[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        borrow = (dig == 4'd0);
      end else begin
        count_dec[4*i +: 4] = dig;
      end
    end
  end

  // Next count: load beats step beats hold.
  always_comb begin
    count_d = count_q;
    if (bus.load)      count_d = load_sat;
    else if (step)     count_d = bus.dec ? count_dec : count_inc;
  end

  // Count prescaler, count register, threshold compare and wrap pulse.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_pre_q   <= '0;
      count_q     <= '0;
      threshold_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      if (!bus.enable || bus.load || step) cnt_pre_q <= '0;
      else                                 cnt_pre_q <= cnt_pre_q + 1'b1;
      count_q     <= count_d;
      threshold_q <= (count_q == bus.threshold_value);
      wrap_q      <= step && (bus.dec ? all0 : all9);
    end
  end

  // Digit shown on the current scan slot and whether it is a blanked leading zero.
  always_comb begin
    sel_digit = count_q[4*int'(sel_q) +: 4];
`ifdef BCD_LEADING_ZERO_BLANK_EN
    sel_blank = (sel_q != 3'd0) && ((count_q >> (4*int'(sel_q))) == '0);
`else
    sel_blank = 1'b0;
`endif
  end

  // Free-running scan prescaler; ptr_q is the next digit to show, sel_q the shown one.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      scan_pre_q <= '0;
      ptr_q      <= '0;
      sel_q      <= '0;
      active_q   <= 1'b0;
      anodes_q   <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      if (scan_tick) begin
        scan_pre_q <= '0;
        sel_q      <= ptr_q;
        ptr_q      <= (ptr_q == 3'(DIGITS - 1)) ? 3'd0 : ptr_q + 3'd1;
        active_q   <= 1'b1;
      end else begin
        scan_pre_q <= scan_pre_q + 1'b1;
      end
      if (active_q) begin
        anodes_q <= ~(8'b1 << sel_q);
        seg_q    <= sel_blank ? 7'h7F : seg_enc(sel_digit);
      end else begin
        anodes_q <= 8'hFF;
        seg_q    <= 7'h7F;
      end
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.threshold = threshold_q;
  assign bus.wrap      = wrap_q;
  assign bus.sevenSeg  = seg_q;
  assign bus.anodes    = anodes_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display with P_C=10, P_S=2, DIGITS=4.
module tb_bcd_counter_display;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  bcd_counter_display_if #(.DIGITS(4)) ifc ();

  bcd_counter_display #(
    .CLK_IN_F(100), .COUNT_F(10), .SCAN_F(50), .DIGITS(4)
  ) dut (
    .clk_in(clk),
    .reset (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    ifc.enable     = 1'b0;
    ifc.load_value = v;
    ifc.load       = 1'b1;
    cyc(1);
    ifc.load       = 1'b0;
  endtask

  task automatic test_reset;
    ifc.enable = 0; ifc.dec = 0; ifc.load = 0;
    ifc.load_value = 16'h0000; ifc.threshold_value = 16'h9000;
    rst_n = 1'b0;
    cyc(3);
    total++; if (ifc.count_bcd !== 16'h0000) begin bad++; $display("FAIL rst_count got=%h exp=0000", ifc.count_bcd); end
    total++; if (ifc.threshold !== 1'b0) begin bad++; $display("FAIL rst_threshold got=%b exp=0", ifc.threshold); end
    total++; if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL rst_wrap got=%b exp=0", ifc.wrap); end
    total++; if (ifc.anodes !== 8'hFF) begin bad++; $display("FAIL rst_anodes got=%h exp=ff", ifc.anodes); end
    total++; if (ifc.sevenSeg !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%b exp=1111111", ifc.sevenSeg); end
    rst_n = 1'b1;
    cyc(2);
    total++; if (ifc.anodes !== 8'hFF) begin bad++; $display("FAIL scan_early got=%h exp=ff", ifc.anodes); end
    cyc(1);
    total++; if (ifc.anodes !== 8'hFE) begin bad++; $display("FAIL scan_first_an got=%h exp=fe", ifc.anodes); end
    total++; if (ifc.sevenSeg !== 7'b0000001) begin bad++; $display("FAIL scan_first_seg got=%b exp=0000001", ifc.sevenSeg); end
  endtask

  task automatic test_count_up;
    logic [15:0] exp;
    int n;
    ifc.dec = 0; ifc.enable = 1;
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      n = k / 10;
      exp = 16'((n / 10) * 16 + (n % 10));
      total++; if (ifc.count_bcd !== exp) begin bad++; $display("FAIL up_count k=%0d got=%h exp=%h", k, ifc.count_bcd, exp); end
      total++; if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL up_wrap k=%0d got=%b exp=0", k, ifc.wrap); end
    end
    ifc.enable = 0;
  endtask

  task automatic test_wrap_up;
    logic [15:0] exp;
    logic        wexp;
    do_load(16'h9998);
    total++; if (ifc.count_bcd !== 16'h9998) begin bad++; $display("FAIL load_9998 got=%h exp=9998", ifc.count_bcd); end
    ifc.dec = 0; ifc.enable = 1;
    for (int k = 1; k <= 25; k++) begin
      cyc(1);
      exp  = (k < 10) ? 16'h9998 : (k < 20) ? 16'h9999 : 16'h0000;
      wexp = (k == 20);
      total++; if (ifc.count_bcd !== exp) begin bad++; $display("FAIL wrapup_count k=%0d got=%h exp=%h", k, ifc.count_bcd, exp); end
      total++; if (ifc.wrap !== wexp) begin bad++; $display("FAIL wrapup_pulse k=%0d got=%b exp=%b", k, ifc.wrap, wexp); end
    end
    ifc.enable = 0;
  endtask

  task automatic test_wrap_down;
    logic [15:0] exp;
    logic        wexp;
    do_load(16'h0000);
    ifc.dec = 1; ifc.enable = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      exp  = (k < 10) ? 16'h0000 : (k < 20) ? 16'h9999 : 16'h9998;
      wexp = (k == 10);
      total++; if (ifc.count_bcd !== exp) begin bad++; $display("FAIL wrapdn_count k=%0d got=%h exp=%h", k, ifc.count_bcd, exp); end
      total++; if (ifc.wrap !== wexp) begin bad++; $display("FAIL wrapdn_pulse k=%0d got=%b exp=%b", k, ifc.wrap, wexp); end
    end
    ifc.enable = 0; ifc.dec = 0;
  endtask

  task automatic test_threshold;
    logic [15:0] exp;
    logic        texp;
    ifc.threshold_value = 16'h0940;
    do_load(16'h0A3F);
    total++; if (ifc.count_bcd !== 16'h0939) begin bad++; $display("FAIL load_sat got=%h exp=0939", ifc.count_bcd); end
    total++; if (ifc.threshold !== 1'b0) begin bad++; $display("FAIL thr_init got=%b exp=0", ifc.threshold); end
    ifc.dec = 0; ifc.enable = 1;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      exp  = (k < 10) ? 16'h0939 : (k < 20) ? 16'h0940 : 16'h0941;
      texp = (k >= 11) && (k <= 20);
      total++; if (ifc.count_bcd !== exp) begin bad++; $display("FAIL thr_count k=%0d got=%h exp=%h", k, ifc.count_bcd, exp); end
      total++; if (ifc.threshold !== texp) begin bad++; $display("FAIL thr_flag k=%0d got=%b exp=%b", k, ifc.threshold, texp); end
    end
    ifc.enable = 0;
  endtask

  task automatic test_scan;
    logic [6:0] exp_seg [4];
    logic [7:0] exp_an;
    logic       seen7, found;
    int         idx;
    exp_seg[0] = 7'b0000110;
    exp_seg[1] = 7'b0010010;
    exp_seg[2] = 7'b1001111;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    exp_seg[3] = 7'h7F;
`else
    exp_seg[3] = 7'b0000001;
`endif
    do_load(16'h0123);
    seen7 = 0; found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      cyc(1);
      if (seen7 && ifc.anodes === 8'hFE) found = 1;
      if (ifc.anodes === 8'hF7) seen7 = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL scan_sync got=timeout exp=anodes fe after f7");
    end else begin
      for (int j = 0; j < 9; j++) begin
        idx = (j / 2) % 4;
        exp_an = ~(8'h01 << idx);
        total++; if (ifc.anodes !== exp_an) begin bad++; $display("FAIL scan_an j=%0d got=%h exp=%h", j, ifc.anodes, exp_an); end
        total++; if (ifc.sevenSeg !== exp_seg[idx]) begin bad++; $display("FAIL scan_seg j=%0d got=%b exp=%b", j, ifc.sevenSeg, exp_seg[idx]); end
        cyc(1);
      end
    end
  endtask

  task automatic test_reset_mid;
    ifc.threshold_value = 16'h0457;
    do_load(16'h0457);
    ifc.dec = 0; ifc.enable = 1;
    cyc(5);
    total++; if (ifc.count_bcd !== 16'h0457) begin bad++; $display("FAIL mid_pre_count got=%h exp=0457", ifc.count_bcd); end
    total++; if (ifc.threshold !== 1'b1) begin bad++; $display("FAIL mid_pre_thr got=%b exp=1", ifc.threshold); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifc.count_bcd !== 16'h0000) begin bad++; $display("FAIL mid_rst_count got=%h exp=0000", ifc.count_bcd); end
    total++; if (ifc.threshold !== 1'b0) begin bad++; $display("FAIL mid_rst_thr got=%b exp=0", ifc.threshold); end
    total++; if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL mid_rst_wrap got=%b exp=0", ifc.wrap); end
    total++; if (ifc.anodes !== 8'hFF) begin bad++; $display("FAIL mid_rst_an got=%h exp=ff", ifc.anodes); end
    total++; if (ifc.sevenSeg !== 7'h7F) begin bad++; $display("FAIL mid_rst_seg got=%b exp=1111111", ifc.sevenSeg); end
    cyc(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      total++;
      if (ifc.count_bcd !== ((k < 10) ? 16'h0000 : 16'h0001)) begin
        bad++; $display("FAIL mid_resume k=%0d got=%h exp=%h", k, ifc.count_bcd, (k < 10) ? 16'h0000 : 16'h0001);
      end
    end
    ifc.enable = 0;
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap_up;
    test_wrap_down;
    test_threshold;
    test_scan;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
